// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and width helpers for the command-channel arbiter
package bus_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int BURST_LEN_MIN = 1;
   localparam int BURST_LEN_MAX = 16;

   function automatic int src_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   function automatic int cnt_width(input int burst_len);
      return $clog2(burst_len + 1);
   endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// rtl/bus_rr_pick.sv - combinational round-robin picker: first set request at or after the pointer
module bus_rr_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_ptr,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   logic [2*N-1:0] w_req2;
   logic [N-1:0]   w_rot;
   logic [W:0]     w_sum;

   // Rotating a doubled copy puts the pointer's request at bit 0.
   assign w_req2 = {i_req, i_req};
   assign w_rot  = N'(w_req2 >> i_ptr);

   always_comb begin
      o_any = |w_rot;
      w_sum = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sum = {1'b0, i_ptr} + (W+1)'(k);
         end
      end
      if (w_sum >= (W+1)'(N)) begin
         w_sum = w_sum - (W+1)'(N);
      end
   end

   assign o_idx = w_sum[W-1:0];

endmodule

// File: rtl/bus_cmd_arbiter.sv
// rtl/bus_cmd_arbiter.sv - round-robin burst arbiter sharing the co-processor command channel
module bus_cmd_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int SRC_W      = src_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            fifo_cmd_valid,
   output logic [NUM_REQ-1:0]            fifo_cmd_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_cmd_wdata,
   output logic                          arb_cmd_valid,
   input  logic                          arb_cmd_ready,
   output logic [DATA_WIDTH-1:0]         arb_cmd_wdata,
   output logic [SRC_W-1:0]              arb_cmd_src
);

   localparam int CNT_W = cnt_width(BURST_LEN);

   arb_state_t            r_state;
   logic [SRC_W-1:0]      r_grant;
   logic [SRC_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]      r_beat_cnt;
   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_wdata;
   logic [SRC_W-1:0]      r_out_src;

   arb_state_t            w_state_nxt;
   logic [SRC_W-1:0]      w_grant_nxt;
   logic [SRC_W-1:0]      w_ptr_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [SRC_W-1:0]      w_pick_idx;
   logic                  w_pick_any;
   logic                  w_load_ok;
   logic                  w_take;
   logic [CNT_W-1:0]      w_cnt_inc;
   logic [SRC_W-1:0]      w_grant_inc;
   logic [DATA_WIDTH-1:0] w_sel_wdata;

   bus_rr_pick #(
      .N (NUM_REQ),
      .W (SRC_W)
   ) u_pick (
      .i_req (fifo_cmd_valid),
      .i_ptr (r_rr_ptr),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   assign w_load_ok   = !r_out_valid || arb_cmd_ready;
   assign w_take      = (r_state == GRANT) && w_load_ok && fifo_cmd_valid[r_grant];
   assign w_cnt_inc   = r_beat_cnt + 1'b1;
   assign w_grant_inc = (r_grant == SRC_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
   assign w_sel_wdata = fifo_cmd_wdata[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_ptr_nxt      = r_rr_ptr;
      w_cnt_nxt      = r_beat_cnt;
      fifo_cmd_ready = '0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_grant_nxt = w_pick_idx;
               w_cnt_nxt   = '0;
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            // A stalled output register freezes the grant entirely.
            if (w_load_ok) begin
               if (fifo_cmd_valid[r_grant]) begin
                  fifo_cmd_ready[r_grant] = 1'b1;
                  w_cnt_nxt               = w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(BURST_LEN)) begin
                     w_state_nxt = IDLE;
                     w_ptr_nxt   = w_grant_inc;
                  end
               end else begin
                  w_state_nxt = IDLE;
                  w_ptr_nxt   = w_grant_inc;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_rr_ptr   <= w_ptr_nxt;
         r_beat_cnt <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_wdata <= '0;
         r_out_src   <= '0;
      end else if (w_take) begin
         r_out_valid <= 1'b1;
         r_out_wdata <= w_sel_wdata;
         r_out_src   <= r_grant;
      end else if (arb_cmd_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign arb_cmd_valid = r_out_valid;
   assign arb_cmd_wdata = r_out_wdata;
   assign arb_cmd_src   = r_out_src;

endmodule
